// File: rtl/requant_scheduler_if.sv
// requant_scheduler_if: sample request, configuration, requantize-unit and result signals of the scheduler.
// The scheduler uses the master view; sources, the unit and the consumer use the slave view.
interface requant_scheduler_if #(
    parameter int NCH = 4,
    parameter int CHW = 2
);
    logic [NCH-1:0]    req_valid;
    logic [18*NCH-1:0] req_data;
    logic [NCH-1:0]    req_ready;
    logic              cfg_we;
    logic [CHW-1:0]    cfg_ch;
    logic [4:0]        cfg_nquant;
    logic [17:0]       rq_datain;
    logic              rq_endatain;
    logic [4:0]        rq_nquant;
    logic [17:0]       rq_dataout;
    logic              out_valid;
    logic [17:0]       out_data;
    logic [CHW-1:0]    out_ch;
    logic              out_ready;
    logic              busy;
    modport master (
        input  req_valid, req_data, cfg_we, cfg_ch, cfg_nquant, rq_dataout, out_ready,
        output req_ready, rq_datain, rq_endatain, rq_nquant, out_valid, out_data, out_ch, busy
    );
    modport slave (
        output req_valid, req_data, cfg_we, cfg_ch, cfg_nquant, rq_dataout, out_ready,
        input  req_ready, rq_datain, rq_endatain, rq_nquant, out_valid, out_data, out_ch, busy
    );
endinterface

// File: rtl/requant_scheduler.sv
// requant_scheduler: round-robin sharing of one requantize unit among NCH sample streams.
// One sample in flight: IDLE grant -> ISSUE strobe -> WAIT unit latency -> OUT until taken.
module requant_scheduler #(
    parameter int NCH    = 4,
    parameter int CHW    = 2,
    parameter int RQ_LAT = 5,
    parameter int NQ_RST = 8
) (
    input logic                 clock,
    input logic                 reset,
    requant_scheduler_if.master io
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, OUT = 2'd3;
    localparam int CW = RQ_LAT > 1 ? $clog2(RQ_LAT) : 1;
    logic [1:0]     state_q, state_d;
    logic [CHW-1:0] ptr_q, grant, idx;
    logic [17:0]    data_q;
    logic [4:0]     nquant_q;
    logic [4:0]     nq_q [NCH];
    logic [CW-1:0]  cnt_q;
    logic           take, live;
    // Scan from ptr+NCH down to ptr+1 so the nearest valid channel after ptr wins.
    always_comb begin
        grant = '0;
        idx = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = CHW'((int'(ptr_q) + k) % NCH);
            grant = io.req_valid[idx] ? idx : grant;
        end
    end
    assign take = state_q == IDLE && |io.req_valid;
    assign live = state_q == ISSUE || state_q == WAIT;
    always_comb
        state_d = take ? ISSUE :
                  state_q == ISSUE ? WAIT :
                  state_q == WAIT ? (cnt_q == '0 ? OUT : WAIT) :
                  state_q == OUT && io.out_ready ? IDLE : state_q;
    assign io.req_ready   = take && !reset ? NCH'(1) << grant : '0;
    assign io.rq_endatain = state_q == ISSUE;
    assign io.rq_datain   = live ? data_q : '0;
    assign io.rq_nquant   = live ? nquant_q : '0;
    assign io.out_valid   = state_q == OUT;
    assign io.out_data    = state_q == OUT ? data_q : '0;
    // The rr pointer is the last granted channel, so it doubles as the result tag.
    assign io.out_ch      = state_q == OUT ? ptr_q : '0;
    assign io.busy        = state_q != IDLE;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q <= CHW'(NCH - 1);
            data_q <= '0;
            nquant_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < NCH; i++) nq_q[i] <= 5'(NQ_RST);
        end else begin
            state_q <= state_d;
            if (take) begin
                ptr_q <= grant;
                data_q <= io.req_data[18*grant +: 18];
                nquant_q <= nq_q[grant];
            end
            if (state_q == ISSUE) cnt_q <= CW'(RQ_LAT - 1);
            if (state_q == WAIT) cnt_q <= cnt_q - CW'(1);
            // The sample is no longer needed once the result arrives, so reuse its register.
            if (state_q == WAIT && cnt_q == '0) data_q <= io.rq_dataout;
            if (io.cfg_we && 32'(io.cfg_ch) < NCH)
                nq_q[io.cfg_ch] <= io.cfg_nquant == 5'd0 ? 5'd1 :
                                   io.cfg_nquant > 5'd17 ? 5'd17 : io.cfg_nquant;
        end
    end
endmodule

// File: tb/tb_requant_scheduler.sv
// tb_requant_scheduler: random and directed stimulus against a cycle-timeline scoreboard,
// with a behavioural requantize unit (round-half-even to Nquant MSBs after RQ_LAT cycles).
module tb_requant_scheduler;
    localparam int NCH = 4, CHW = 2, RQ_LAT = 5, NQ_RST = 8;
    typedef struct packed { logic [17:0] d; logic [4:0] nq; } iss_t;
    typedef struct packed { logic [17:0] d; logic [CHW-1:0] ch; } res_t;
    logic clock, reset;
    requant_scheduler_if #(.NCH(NCH), .CHW(CHW)) ifc ();
    requant_scheduler #(.NCH(NCH), .CHW(CHW), .RQ_LAT(RQ_LAT), .NQ_RST(NQ_RST)) dut (
        .clock(clock), .reset(reset), .io(ifc)
    );
    int checks = 0, errors = 0, cyc = 0;
    logic [NCH-1:0] acc;
    iss_t iq[$];
    res_t oq[$];
    iss_t cur;
    bit pending = 0;
    int acc_cyc = 0, mptr = NCH - 1, g;
    int nq_m [NCH];
    logic [CHW-1:0] j;
    logic [NCH-1:0] exp_rdy;
    logic [17:0] pipe [RQ_LAT+1];

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    function automatic logic [17:0] requant(input logic [17:0] x, input int nq);
        int drop = 18 - nq;
        int v = int'(signed'(x));
        int q, r, half, top;
        if (drop <= 0) return x;
        q = v >>> drop;
        r = v - (q <<< drop);
        half = 1 << (drop - 1);
        if (r > half || (r == half && (q & 1) == 1)) q++;
        top = (1 << (nq - 1)) - 1;
        if (q > top) q = top;
        return 18'(q <<< drop);
    endfunction

    function automatic int clamp(input int v);
        return v < 1 ? 1 : (v > 17 ? 17 : v);
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // Requantize unit model: delay line of RQ_LAT cycles, random junk when nothing was issued.
    initial begin
        foreach (pipe[i]) pipe[i] = '0;
        ifc.rq_dataout = '0;
        forever begin
            @(negedge clock);
            for (int i = RQ_LAT; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = ifc.rq_endatain ? requant(ifc.rq_datain, int'(ifc.rq_nquant)) : 18'($urandom);
            ifc.rq_dataout = pipe[RQ_LAT];
        end
    end

    // Monitor and scoreboard: a sample accepted at cycle t is issued at t+1 and offered from t+RQ_LAT+2.
    initial begin
        foreach (nq_m[i]) nq_m[i] = NQ_RST;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                pending = 0;
                iq.delete();
                oq.delete();
                mptr = NCH - 1;
                foreach (nq_m[i]) nq_m[i] = NQ_RST;
            end else begin
                g = -1;
                if (!pending)
                    for (int k = 1; k <= NCH; k++) begin
                        j = CHW'((mptr + k) % NCH);
                        if (g < 0 && ifc.req_valid[j]) g = int'(j);
                    end
                exp_rdy = g >= 0 ? NCH'(1) << g : '0;
                chk("req_ready", ifc.req_ready, exp_rdy);
                chk("busy", ifc.busy, pending);
                chk("rq_endatain", ifc.rq_endatain, pending && cyc == acc_cyc + 1);
                chk("out_valid", ifc.out_valid, pending && cyc >= acc_cyc + RQ_LAT + 2);
                if (!pending) begin
                    chk("rq_datain_idle", ifc.rq_datain, 0);
                    chk("rq_nquant_idle", ifc.rq_nquant, 0);
                end
                if (ifc.rq_endatain && iq.size() > 0) begin
                    cur = iq.pop_front();
                    chk("issue_data", ifc.rq_datain, cur.d);
                    chk("issue_nquant", ifc.rq_nquant, cur.nq);
                end else if (pending && cyc > acc_cyc + 1 && cyc <= acc_cyc + RQ_LAT + 1) begin
                    chk("hold_data", ifc.rq_datain, cur.d);
                    chk("hold_nquant", ifc.rq_nquant, cur.nq);
                end
                if (ifc.out_valid) begin
                    chk("result_expected", oq.size() > 0, 1);
                    if (oq.size() > 0) begin
                        chk("out_data", ifc.out_data, oq[0].d);
                        chk("out_ch", ifc.out_ch, oq[0].ch);
                        if (ifc.out_ready) begin
                            void'(oq.pop_front());
                            pending = 0;
                        end
                    end
                end
                if (g >= 0) begin
                    j = CHW'(g);
                    iq.push_back('{d: ifc.req_data[18*g +: 18], nq: 5'(nq_m[j])});
                    oq.push_back('{d: requant(ifc.req_data[18*g +: 18], nq_m[j]), ch: j});
                    pending = 1;
                    acc_cyc = cyc;
                    mptr = g;
                end
                if (ifc.cfg_we) begin
                    j = ifc.cfg_ch;
                    nq_m[j] = clamp(int'(ifc.cfg_nquant));
                end
            end
        end
    end

    task automatic step();
        @(negedge clock);
        acc = ifc.req_ready;
        @(posedge clock);
        #1;
    endtask

    task automatic refresh();
        for (int i = 0; i < NCH; i++)
            if (acc[i]) ifc.req_data[18*i +: 18] = 18'($urandom);
    endtask

    task automatic drop_accepted();
        for (int i = 0; i < NCH; i++)
            if (acc[i]) ifc.req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        ifc.req_valid = '0;
        ifc.out_ready = 1'b1;
        repeat (2 * RQ_LAT + 6) step();
    endtask

    task automatic check_idle(input string n);
        @(negedge clock);
        chk({n, "_req_ready"}, ifc.req_ready, 0);
        chk({n, "_rq_endatain"}, ifc.rq_endatain, 0);
        chk({n, "_rq_datain"}, ifc.rq_datain, 0);
        chk({n, "_rq_nquant"}, ifc.rq_nquant, 0);
        chk({n, "_out_valid"}, ifc.out_valid, 0);
        chk({n, "_out_data"}, ifc.out_data, 0);
        chk({n, "_out_ch"}, ifc.out_ch, 0);
        chk({n, "_busy"}, ifc.busy, 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1;
        ifc.req_valid = '0;
        ifc.req_data = '0;
        ifc.cfg_we = 0;
        ifc.cfg_ch = '0;
        ifc.cfg_nquant = '0;
        ifc.out_ready = 1;
        acc = '0;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        check_idle("reset");
        // Single sample on ch1 with Nquant 8.
        ifc.cfg_we = 1; ifc.cfg_ch = 2'd1; ifc.cfg_nquant = 5'd8;
        step();
        ifc.cfg_we = 0;
        ifc.req_valid = 4'b0010;
        ifc.req_data[18 +: 18] = 18'h00280;
        repeat (RQ_LAT + 8) begin step(); drop_accepted(); end
        // All channels continuously valid: rotating grants.
        ifc.req_valid = '1;
        for (int i = 0; i < NCH; i++) ifc.req_data[18*i +: 18] = 18'($urandom);
        repeat (5 * (RQ_LAT + 3) + 2) begin step(); refresh(); end
        drain();
        // Backpressure: result held while out_ready stays low.
        ifc.out_ready = 0;
        ifc.req_valid = '1;
        repeat (RQ_LAT + 24) begin step(); refresh(); end
        ifc.out_ready = 1;
        repeat (RQ_LAT + 6) begin step(); refresh(); end
        drain();
        // Nquant write in the grant cycle applies only to later grants; clamped writes.
        ifc.req_valid = 4'b0100;
        ifc.req_data[36 +: 18] = 18'h1a5c3;
        ifc.cfg_we = 1; ifc.cfg_ch = 2'd2; ifc.cfg_nquant = 5'd12;
        step();
        ifc.cfg_we = 0;
        refresh();
        repeat (2 * (RQ_LAT + 3) + 2) begin step(); refresh(); end
        ifc.req_valid = '0;
        drain();
        ifc.cfg_we = 1; ifc.cfg_ch = 2'd0; ifc.cfg_nquant = 5'd0;
        step();
        ifc.cfg_ch = 2'd1; ifc.cfg_nquant = 5'd25;
        step();
        ifc.cfg_we = 0;
        ifc.req_valid = 4'b0011;
        ifc.req_data[0 +: 18] = 18'h0ffff;
        ifc.req_data[18 +: 18] = 18'h2aaab;
        repeat (2 * (RQ_LAT + 3) + 4) begin step(); drop_accepted(); end
        drain();
        // Reset while waiting on the unit aborts the sample.
        ifc.req_valid = 4'b0010;
        repeat (3) begin step(); drop_accepted(); end
        reset = 1;
        ifc.req_valid = '0;
        step();
        reset = 0;
        check_idle("abort");
        ifc.req_valid = '1;
        repeat (RQ_LAT + 6) begin step(); refresh(); end
        drain();
        // Pointer wrap from ch3 to ch0.
        ifc.req_valid = 4'b1000;
        repeat (2 * (RQ_LAT + 3) + 2) begin
            step();
            if (acc[3] && !ifc.req_valid[0]) begin
                ifc.req_valid = 4'b1001;
                refresh();
            end else drop_accepted();
        end
        drain();
        // Random traffic, configuration, backpressure and occasional reset.
        repeat (3000) begin
            step();
            for (int i = 0; i < NCH; i++) begin
                if (acc[i] || (ifc.req_valid[i] && $urandom_range(7) == 0)) ifc.req_valid[i] = 1'b0;
                else if (!ifc.req_valid[i] && $urandom_range(2) == 0) begin
                    ifc.req_valid[i] = 1'b1;
                    ifc.req_data[18*i +: 18] = 18'($urandom);
                end
            end
            ifc.cfg_we = $urandom_range(5) == 0;
            ifc.cfg_ch = CHW'($urandom);
            ifc.cfg_nquant = 5'($urandom);
            ifc.out_ready = $urandom_range(3) != 0;
            reset = $urandom_range(399) == 0;
        end
        reset = 0;
        ifc.cfg_we = 0;
        drain();
        chk("drained", oq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
